// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-memory responder: access sizes, MMIO
// register offsets and the address-region decoder.
package mem_map_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_MMIO = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  localparam logic [3:0] OFF_CYCLE   = 4'h0;
  localparam logic [3:0] OFF_GPIO    = 4'h4;
  localparam logic [3:0] OFF_HALT    = 4'h8;
  localparam logic [3:0] OFF_ERRADDR = 4'hC;

  // RAM wins first; the MMIO block is a single 16-byte window.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    region_e r;
    if (addr < ram_bytes)
      r = REGION_RAM;
    else if (addr[31:4] == mmio_base[31:4])
      r = REGION_MMIO;
    else
      r = REGION_NONE;
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_gen.sv
// Turns an access size and low address bits into byte enables, replicated
// store lanes and a misalignment flag (illegal sizes count as misaligned).
module byte_lane_gen
  import mem_map_pkg::*;
(
  input  logic [2:0]  mem_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    byte_en    = 4'h0;
    lane_data  = wr_data;
    misaligned = 1'b0;
    case (mem_type)
      SZ_B, SZ_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{wr_data[7:0]}};
      end
      SZ_H, SZ_HU: begin
        byte_en    = 4'b0011 << addr_lo;
        lane_data  = {2{wr_data[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        byte_en    = 4'hF;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's stage-3 data-memory port: word RAM with
// combinational read, plus cycle/GPIO/halt/error-address MMIO registers.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic [31:0] gpio_out,
  output logic        halted,
  output logic [31:0] halt_code,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] cycle_reg;
  logic [31:0] gpio_reg;
  logic        halted_reg;
  logic [31:0] halt_code_reg;
  logic        err_reg;
  logic [31:0] err_addr_reg;

  logic [3:0]       byte_en;
  logic [31:0]      lane_data;
  logic             misaligned;
  region_e          region;
  logic [IDX_W-1:0] ram_idx;
  logic [3:0]       mmio_off;
  logic             rd_err;
  logic             wr_err;
  logic             any_err;
  logic             ram_we;
  logic             mmio_we;
  logic [31:0]      mmio_rdata;

  byte_lane_gen u_lanes (
    .mem_type   (MEM_type),
    .addr_lo    (MEM_addr[1:0]),
    .wr_data    (MEM_WR_out),
    .byte_en    (byte_en),
    .lane_data  (lane_data),
    .misaligned (misaligned)
  );

  assign region   = decode_region(MEM_addr, RAM_BYTES, MMIO_BASE);
  assign ram_idx  = MEM_addr[IDX_W+1:2];
  assign mmio_off = {MEM_addr[3:2], 2'b00};

  // Sub-word stores into MMIO are faults; sub-word MMIO loads are not.
  assign rd_err  = MEM_rd_en && (misaligned || region == REGION_NONE);
  assign wr_err  = MEM_wr_en && (misaligned || region == REGION_NONE ||
                   (region == REGION_MMIO && MEM_type != SZ_W));
  assign any_err = rd_err || wr_err;
  assign ram_we  = MEM_wr_en && !wr_err && region == REGION_RAM;
  assign mmio_we = MEM_wr_en && !wr_err && region == REGION_MMIO;

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      OFF_CYCLE:   mmio_rdata = cycle_reg;
      OFF_GPIO:    mmio_rdata = gpio_reg;
      OFF_HALT:    mmio_rdata = halt_code_reg;
      OFF_ERRADDR: mmio_rdata = err_addr_reg;
      default:     mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    MEM_data = 32'h0;
    if (MEM_rd_en && !rd_err) begin
      if (region == REGION_RAM)
        MEM_data = ram[ram_idx];
      else if (region == REGION_MMIO)
        MEM_data = mmio_rdata;
    end
  end

  // RAM is not reset, but a store presented during reset is dropped.
  always_ff @(posedge CLK) begin
    if (!rst && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          ram[ram_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cycle_reg     <= 32'h0;
      gpio_reg      <= 32'h0;
      halted_reg    <= 1'b0;
      halt_code_reg <= 32'h0;
      err_reg       <= 1'b0;
      err_addr_reg  <= 32'h0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (mmio_we && mmio_off == OFF_GPIO)
        gpio_reg <= MEM_WR_out;
      if (mmio_we && mmio_off == OFF_HALT) begin
        halted_reg    <= 1'b1;
        halt_code_reg <= MEM_WR_out;
      end
      // First fault since reset owns err_addr.
      if (any_err) begin
        err_reg <= 1'b1;
        if (!err_reg)
          err_addr_reg <= MEM_addr;
      end
    end
  end

  assign gpio_out  = gpio_reg;
  assign halted    = halted_reg;
  assign halt_code = halt_code_reg;
  assign err       = err_reg;
  assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: inputs change on the falling edge,
// load data is checked mid-low-phase, register outputs after the next edge.
module tb_data_mem_responder;

  localparam logic [31:0] MMIO = 32'h8000_0000;
  localparam logic [2:0]  T_B  = 3'b000;
  localparam logic [2:0]  T_H  = 3'b001;
  localparam logic [2:0]  T_W  = 3'b010;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] MEM_addr = 32'h0;
  logic [31:0] MEM_WR_out = 32'h0;
  logic [2:0]  MEM_type = T_W;
  logic        MEM_rd_en = 1'b0;
  logic        MEM_wr_en = 1'b0;
  logic [31:0] MEM_data;
  logic [31:0] gpio_out;
  logic        halted;
  logic [31:0] halt_code;
  logic        err;
  logic [31:0] err_addr;

  int n_total = 0;
  int n_bad   = 0;

  data_mem_responder dut (
    .CLK        (CLK),
    .rst        (rst),
    .MEM_addr   (MEM_addr),
    .MEM_WR_out (MEM_WR_out),
    .MEM_type   (MEM_type),
    .MEM_rd_en  (MEM_rd_en),
    .MEM_wr_en  (MEM_wr_en),
    .MEM_data   (MEM_data),
    .gpio_out   (gpio_out),
    .halted     (halted),
    .halt_code  (halt_code),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Present one request; it is sampled at the following rising edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] ty,
                       input logic [31:0] addr, input logic [31:0] data);
    MEM_rd_en  = rd;
    MEM_wr_en  = wr;
    MEM_type   = ty;
    MEM_addr   = addr;
    MEM_WR_out = data;
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, T_W, 32'h0, 32'h0);
  endtask

  task automatic next();
    @(negedge CLK);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    next();
    next();
    rst = 1'b0;
    repeat (5) next();

    // Reset state and cycle counter
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_halt_code", halt_code, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("idle_data", MEM_data, 32'h0);
    issue(1'b1, 1'b0, T_W, MMIO, 32'h0);
    chk("cycle_cnt", MEM_data, 32'd5);
    next();

    // Byte/half merging into one RAM word
    issue(1'b0, 1'b1, T_W, 32'h10, 32'h1122_3344); next();
    issue(1'b0, 1'b1, T_B, 32'h11, 32'h0000_00AA); next();
    issue(1'b0, 1'b1, T_H, 32'h12, 32'h0000_BEEF); next();
    issue(1'b1, 1'b0, T_W, 32'h10, 32'h0);
    chk("merge_lw", MEM_data, 32'hBEEF_AA44);
    issue(1'b1, 1'b0, T_B, 32'h13, 32'h0);
    chk("merge_lb_word", MEM_data, 32'hBEEF_AA44);
    issue(1'b0, 1'b1, T_W, 32'hFFC, 32'hA5A5_0FF0); next();
    issue(1'b1, 1'b0, T_W, 32'hFFC, 32'h0);
    chk("last_word", MEM_data, 32'hA5A5_0FF0);
    issue(1'b0, 1'b1, T_W, 32'h20, 32'hCAFE_F00D); next();

    // GPIO write, readback, then a faulting sub-word MMIO store
    issue(1'b0, 1'b1, T_W, MMIO + 32'h4, 32'hDEAD_BEEF); next();
    chk("gpio_wr", gpio_out, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, T_W, MMIO + 32'h4, 32'h0);
    chk("gpio_rd", MEM_data, 32'hDEAD_BEEF);
    chk("gpio_no_err", {31'h0, err}, 32'h0);
    issue(1'b0, 1'b1, T_B, MMIO + 32'h4, 32'h0000_0012); next();
    chk("mmio_sb_err", {31'h0, err}, 32'h1);
    chk("mmio_sb_err_addr", err_addr, MMIO + 32'h4);
    chk("mmio_sb_gpio", gpio_out, 32'hDEAD_BEEF);

    // Misaligned store, then unmapped load keeps first fault address
    idle();
    pulse_reset();
    issue(1'b0, 1'b1, T_W, MMIO, 32'h1234_0000); next();
    chk("ro_store_no_err", {31'h0, err}, 32'h0);
    issue(1'b0, 1'b1, T_H, 32'h21, 32'h0000_1234); next();
    chk("misal_err", {31'h0, err}, 32'h1);
    chk("misal_err_addr", err_addr, 32'h21);
    issue(1'b1, 1'b0, T_W, 32'h20, 32'h0);
    chk("misal_ram_kept", MEM_data, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, T_W, 32'h4000_0000, 32'h0);
    chk("unmapped_rd", MEM_data, 32'h0);
    next();
    chk("first_fault_wins", err_addr, 32'h21);
    issue(1'b1, 1'b0, T_W, 32'h1000, 32'h0);
    chk("past_ram_rd", MEM_data, 32'h0);
    issue(1'b1, 1'b0, T_W, 32'h22, 32'h0);
    chk("misal_lw_zero", MEM_data, 32'h0);
    issue(1'b1, 1'b0, T_W, MMIO + 32'hC, 32'h0);
    chk("err_addr_mmio_rd", MEM_data, 32'h21);
    next();

    // Halt, second halt write, then reset with a discarded store
    issue(1'b0, 1'b1, T_W, MMIO + 32'h8, 32'h0000_0001); next();
    chk("halted_set", {31'h0, halted}, 32'h1);
    chk("halt_code", halt_code, 32'h1);
    issue(1'b0, 1'b1, T_W, MMIO + 32'h8, 32'h0000_0007); next();
    chk("halt_code_2", halt_code, 32'h7);
    chk("halted_sticky", {31'h0, halted}, 32'h1);
    rst = 1'b1;
    issue(1'b0, 1'b1, T_W, 32'h10, 32'h0000_0099);
    next();
    rst = 1'b0;
    idle();
    chk("rst2_halted", {31'h0, halted}, 32'h0);
    chk("rst2_halt_code", halt_code, 32'h0);
    chk("rst2_err", {31'h0, err}, 32'h0);
    chk("rst2_gpio", gpio_out, 32'h0);
    issue(1'b1, 1'b0, T_W, 32'h10, 32'h0);
    chk("ram_survives_rst", MEM_data, 32'hBEEF_AA44);
    next();

    // Simultaneous read and write returns old data
    issue(1'b0, 1'b1, T_W, 32'h30, 32'h1234_5678); next();
    issue(1'b1, 1'b1, T_W, 32'h30, 32'h5555_5555);
    chk("rdwr_old", MEM_data, 32'h1234_5678);
    next();
    issue(1'b1, 1'b0, T_W, 32'h30, 32'h0);
    chk("rdwr_new", MEM_data, 32'h5555_5555);
    chk("rdwr_no_err", {31'h0, err}, 32'h0);
    next();
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. It answers the stage-3 load/store requests the core issues on its MEM_* ports.
- Contains word-organised data RAM plus a small MMIO register block: cycle counter, GPIO output, halt/tohost, error address.
- Reads are combinational, because the core consumes read data in the same cycle. Writes and all register updates are synchronous.
- Sits beside the core in the SoC/testbench top, replacing the behavioural data memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit RAM words. RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- MMIO_BASE, 32'h8000_0000: base byte address of the MMIO block. Offsets are 0x0, 0x4, 0x8, 0xC.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- MEM_addr  input  32  byte address from core
- MEM_WR_out  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- MEM_type  input  3  access size/sign, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- MEM_rd_en  input  1  load request this cycle
- MEM_wr_en  input  1  store request this cycle
- MEM_data  output  32  full aligned word at MEM_addr; the core extracts and extends it
- gpio_out  output  32  GPIO register
- halted  output  1  sticky halt flag
- halt_code  output  32  value written to HALT
- err  output  1  sticky access-error flag
- err_addr  output  32  address of first faulting access

Behaviour:
- Reset: one cycle with rst=1 clears gpio_out, halted, halt_code, err, err_addr and the cycle counter to 0. RAM contents are not reset. Reset asserted mid-operation discards any store presented in that cycle.
- Region decode:
  - RAM when MEM_addr < 4*DEPTH_WORDS.
  - MMIO when MEM_addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- Misalignment rules:
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]!=0.
  - Types 011/110/111 are illegal and treated as misaligned.
- Load (MEM_rd_en=1), latency 0:
  - MEM_data is valid in the same cycle it is requested.
  - RAM returns word[addr>>2].
  - MMIO returns: +0x0 cycle counter, +0x4 gpio_out, +0x8 halt_code, +0xC err_addr.
  - Unmapped returns 0.
  - When MEM_rd_en=0, MEM_data is 0.
- Store (MEM_wr_en=1), written at the next rising edge:
  - RAM byte enables: B sets bit addr[1:0]; H sets 2'b11 << addr[1:0]; W sets 4'hF.
  - Data lanes are replicated: B gives {4{d[7:0]}}, H gives {2{d[15:0]}}.
- MMIO stores:
  - Only aligned W stores are accepted. Sub-word MMIO stores are errors and are ignored.
  - +0x4 writes gpio_out.
  - +0x8 sets halted=1 and halt_code=data.
  - +0x0 and +0xC are read-only: the store is ignored and is not an error.
- Errors:
  - An error is a misaligned access, an unmapped access, or a sub-word MMIO store.
  - On an error, no state is written. err is set the next cycle.
  - err_addr captures MEM_addr only if err was 0; the first fault wins.
  - A load error still returns 0 on MEM_data.
- Cycle counter:
  - Increments every cycle when not in reset; wraps at 2^32.
  - A read returns the pre-increment value for that cycle.
- Simultaneous MEM_rd_en and MEM_wr_en:
  - The store is performed.
  - MEM_data returns the old (pre-write) contents.
  - Errors from either side are reported, recorded once.
- Store-then-load to the same address in consecutive cycles returns the new data. There is no hazard because the write completes at the edge.
- Once halted=1 it stays 1 until reset. A second HALT write updates halt_code. All other accesses continue normally.

Decomposition:
- Shared package mem_map_pkg:
  - size enum (SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101)
  - MMIO offset constants (OFF_CYCLE, OFF_GPIO, OFF_HALT, OFF_ERRADDR)
  - region-decode function
- One sub-module, byte_lane_gen (combinational):
  - Inputs: MEM_type, addr[1:0], store data.
  - Outputs: 4-bit byte enables, lane-replicated 32-bit data, misaligned flag.
- The top holds the RAM array, the MMIO registers and the error capture logic.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0; a load of MMIO_BASE+0x0 returns 5 ±0 relative to reset release (exact count checked).
- SW 0x1122_3344 @0x10; SB 0xAA @0x11; SH 0xBEEF @0x12; LW @0x10 -> MEM_data=0xBEEF_AA44 the cycle after the last store.
- SW 0xDEAD_BEEF @MMIO_BASE+0x4 -> gpio_out=0xDEADBEEF next cycle; LW same address returns it; SB to same address -> err=1, err_addr=MMIO_BASE+0x4, gpio_out unchanged.
- SH @0x21 (misaligned) -> RAM word 0x20 unchanged, err=1, err_addr=0x21; later LW @0x4000_0000 (unmapped) -> MEM_data=0, err_addr stays 0x21.
- SW 0x0000_0001 @MMIO_BASE+0x8 -> halted=1, halt_code=1; assert rst one cycle -> halted=0, halt_code=0, err=0, and RAM word previously written still reads back unchanged.
- MEM_rd_en and MEM_wr_en both high, SW 0x5555_5555 @0x30 over old 0x1234_5678 -> MEM_data=0x1234_5678 that cycle; LW @0x30 next cycle -> 0x5555_5555.
